// File: rtl/riscv_defs.sv
// Shared RISC-V definitions: opcodes, ALUOp encodings and the decoded control bundle.
package riscv_defs;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID inputs, registered EX outputs and stall controls.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [1:0]                id_ALUOp;
  logic                      id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite;
  logic [DATA_WIDTH-1:0]     id_pc, id_readData1, id_readData2, id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]                id_funct;
  logic                      flush;

  logic                      ex_valid;
  logic [1:0]                ex_ALUOp;
  logic                      ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUSrc, ex_regWrite;
  logic [DATA_WIDTH-1:0]     ex_pc, ex_readData1, ex_readData2, ex_imm;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]                ex_funct;
  logic                      pcWrite, ifidWrite;
  logic [15:0]               stall_count;

  modport master (
    output id_valid, id_ALUOp, id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc,
           id_regWrite, id_pc, id_readData1, id_readData2, id_imm, id_rs1, id_rs2, id_rd,
           id_funct, flush,
    input  ex_valid, ex_ALUOp, ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUSrc,
           ex_regWrite, ex_pc, ex_readData1, ex_readData2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct, pcWrite, ifidWrite, stall_count
  );

  modport slave (
    input  id_valid, id_ALUOp, id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc,
           id_regWrite, id_pc, id_readData1, id_readData2, id_imm, id_rs1, id_rs2, id_rd,
           id_funct, flush,
    output ex_valid, ex_ALUOp, ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUSrc,
           ex_regWrite, ex_pc, ex_readData1, ex_readData2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct, pcWrite, ifidWrite, stall_count
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: a load in EX whose rd feeds the instruction in ID.
module hazard_detection_unit #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid,
  input  logic                      ex_memRead,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      flush,
  output logic                      hazard,
  output logic                      pcWrite,
  output logic                      ifidWrite
);
  assign hazard = ex_valid & ex_memRead & (ex_rd != '0) & id_valid &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A flush discards the ID instruction anyway, so there is nothing to hold.
  assign pcWrite   = ~(hazard & ~flush);
  assign ifidWrite = ~(hazard & ~flush);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);
  import riscv_defs::*;

  ctrl_t                     id_ctrl, ex_ctrl_q;
  logic                      ex_valid_q;
  logic [DATA_WIDTH-1:0]     ex_pc_q, ex_rd1_q, ex_rd2_q, ex_imm_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [3:0]                ex_funct_q;
  logic [15:0]               stall_cnt;
  logic                      hazard;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign id_ctrl = '{alu_op: bus.id_ALUOp, branch: bus.id_branch, mem_read: bus.id_memRead,
                     mem_to_reg: bus.id_memtoReg, mem_write: bus.id_memWrite,
                     alu_src: bus.id_ALUSrc, reg_write: bus.id_regWrite};

  hazard_detection_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hdu (
    .ex_valid   (ex_valid_q),
    .ex_memRead (ex_ctrl_q.mem_read),
    .ex_rd      (ex_rd_q),
    .id_valid   (bus.id_valid),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .flush      (bus.flush),
    .hazard     (hazard),
    .pcWrite    (bus.pcWrite),
    .ifidWrite  (bus.ifidWrite)
  );

  // ID -> EX register; reset, flush and bubble all leave an empty slot behind.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || hazard) begin
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_funct_q <= '0;
    end else begin
      ex_ctrl_q  <= bus.id_valid ? id_ctrl : '0;
      ex_valid_q <= bus.id_valid;
      ex_pc_q    <= bus.id_pc;
      ex_rd1_q   <= bus.id_readData1;
      ex_rd2_q   <= bus.id_readData2;
      ex_imm_q   <= bus.id_imm;
      ex_rs1_q   <= bus.id_rs1;
      ex_rs2_q   <= bus.id_rs2;
      ex_rd_q    <= bus.id_rd;
      ex_funct_q <= bus.id_funct;
    end
  end

  // Only a bubble that actually gets inserted is counted; a flush outranks it.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!bus.flush && hazard)
      stall_cnt <= sat_inc(stall_cnt);
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_ALUOp     = ex_ctrl_q.alu_op;
  assign bus.ex_branch    = ex_ctrl_q.branch;
  assign bus.ex_memRead   = ex_ctrl_q.mem_read;
  assign bus.ex_memtoReg  = ex_ctrl_q.mem_to_reg;
  assign bus.ex_memWrite  = ex_ctrl_q.mem_write;
  assign bus.ex_ALUSrc    = ex_ctrl_q.alu_src;
  assign bus.ex_regWrite  = ex_ctrl_q.reg_write;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.ex_readData1 = ex_rd1_q;
  assign bus.ex_readData2 = ex_rd2_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_rs1       = ex_rs1_q;
  assign bus.ex_rs2       = ex_rs2_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_funct     = ex_funct_q;
  assign bus.stall_count  = stall_cnt;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of PC/operand/immediate datapaths.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register-index width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 id_ALUOp, id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite  input  2/1/1/1/1/1/1  decoded control from the main control decoder.
REQ-008 id_pc, id_readData1, id_readData2, id_imm  input  DATA_WIDTH each  PC, register-file reads, sign-extended immediate.
REQ-009 id_rs1, id_rs2, id_rd  input  REG_ADDR_WIDTH each  source/destination indices.
REQ-010 id_funct  input  4  {instr[30], instr[14:12]} for ALU control.
REQ-011 flush  input  1  taken branch resolved downstream; discard ID instruction.
REQ-012 ex_* outputs  output  widths match REQ-007..REQ-010  registered copies, plus ex_valid (1).
REQ-013 pcWrite, ifidWrite  output  1 each  0 = hold PC and IF/ID register.
REQ-014 stall_count  output  16  saturating count of load-use bubbles inserted.

Function
REQ-015 Hazard SHALL be combinational: hazard = ex_valid & ex_memRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-016 pcWrite = ifidWrite = ~(hazard & ~flush); both 1 when no hazard.
REQ-017 Each rising edge, priority flush > hazard > normal.
REQ-018 Flush: all ex_ control bits, ex_ALUOp and ex_valid load 0; datapath fields don't-care but SHALL load 0.
REQ-019 Hazard (no flush): bubble -- ex_ control bits, ex_ALUOp, ex_valid load 0; stall_count increments unless 16'hFFFF.
REQ-020 Normal: every ex_ output loads its id_ counterpart; ex_valid <= id_valid; if id_valid = 0, control bits load 0.
REQ-021 Latency: one cycle ID to EX; a load-use pair incurs exactly one bubble, the dependent instruction enters EX the following edge.
REQ-022 Flush and hazard same cycle: flush wins, no stall, stall_count unchanged.
REQ-023 Back-to-back loads with chained dependence SHALL each produce one bubble; no deadlock, since the bubble clears ex_memRead.
REQ-024 rd = x0 never causes a hazard; rs match against a store's rs2 SHALL still stall.
REQ-025 stall_count SHALL saturate at 16'hFFFF, never wrap.

Reset
REQ-026 reset = 1 at an edge: all ex_ outputs, ex_valid and stall_count <= 0; overrides flush and hazard.
REQ-027 During and after reset pcWrite = ifidWrite = 1 (ex_valid = 0 means no hazard).
REQ-028 Reset mid-stall SHALL clear the bubble state; first post-reset instruction SHALL not be held.

Structure
REQ-029 Shared riscv_defs package SHALL hold opcode constants (R 0110011, LD 0000011, ADDI 0010011, SD 0100011, SB 1100011), ALUOp encodings (00 add, 01 sub/branch, 10 funct-decoded) and the control-bundle typedef.
REQ-030 Hazard logic (REQ-015/016) SHALL be a sub-module hazard_detection_unit; pipeline register and counter stay in id_ex_stage.

Verification
REQ-031 Reset with id inputs nonzero -> all ex_ = 0, stall_count = 0, pcWrite = ifidWrite = 1.
REQ-032 ld x5 (memRead=1, rd=5) then add rs1=5 -> one cycle pcWrite=0, ifidWrite=0, EX gets bubble (ex_regWrite=0), next edge add in EX, stall_count = 1.
REQ-033 ld rd=0 then add rs1=0 -> no stall, stall_count = 0.
REQ-034 Hazard and flush same cycle -> pcWrite = 1, ex_valid = 0, stall_count unchanged.
REQ-035 addi x1, id_imm = 64'hFFFF_FFFF_FFFF_FFF0 -> next edge ex_imm equal, ex_ALUSrc = 1, ex_ALUOp = 00, ex_regWrite = 1.
REQ-036 stall_count forced near 16'hFFFE, three load-use pairs -> ends 16'hFFFF.
